// File: rtl/cluster_pwr_pkg.sv
// ---------------------------------------------------------------------------
// cluster_pwr_pkg
// Shared types and default timing for the cluster power sequencer.
//   seq_state_e          : 3-bit FSM state, also read back by SoC control status
//   DEF_SETTLE_CYCLES    : clock-enable to de-isolation settle time
//   DEF_RST_CYCLES       : minimum reset hold around de-isolation / power-down
//   DEF_ACK_TIMEOUT      : cycles allowed for a power-switch ack edge
//   DEF_CNT_WIDTH        : counter width able to hold the largest of the above
// ---------------------------------------------------------------------------
package cluster_pwr_pkg;

  typedef enum logic [2:0] {
    SEQ_OFF         = 3'd0,
    SEQ_PWR_UP      = 3'd1,
    SEQ_CLK_UP      = 3'd2,
    SEQ_DEISO       = 3'd3,
    SEQ_RUN         = 3'd4,
    SEQ_RST_DN      = 3'd5,
    SEQ_PWR_DN_WAIT = 3'd6
  } seq_state_e;

  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_RST_CYCLES    = 8;
  localparam int DEF_ACK_TIMEOUT   = 1024;
  localparam int DEF_CNT_WIDTH     = 11;

endpackage

// File: rtl/cluster_pwr_seq_if.sv
// ---------------------------------------------------------------------------
// cluster_pwr_seq_if
// Bundles the software controls, the power-switch ack and the cluster-domain
// controls/status of the power sequencer.
//   master : drives software controls and ack, observes sequencer outputs
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface cluster_pwr_seq_if;

  logic       cluster_pow_i;
  logic       cluster_byp_i;
  logic       cluster_rstn_i;
  logic       cluster_fetch_enable_i;
  logic       pwr_ack_i;
  logic       cluster_pwr_en_o;
  logic       cluster_clk_en_o;
  logic       cluster_iso_o;
  logic       cluster_rstn_o;
  logic       cluster_fetch_enable_o;
  logic [2:0] seq_state_o;
  logic       seq_err_o;

  modport master (
    output cluster_pow_i, cluster_byp_i, cluster_rstn_i,
           cluster_fetch_enable_i, pwr_ack_i,
    input  cluster_pwr_en_o, cluster_clk_en_o, cluster_iso_o,
           cluster_rstn_o, cluster_fetch_enable_o, seq_state_o, seq_err_o
  );

  modport slave (
    input  cluster_pow_i, cluster_byp_i, cluster_rstn_i,
           cluster_fetch_enable_i, pwr_ack_i,
    output cluster_pwr_en_o, cluster_clk_en_o, cluster_iso_o,
           cluster_rstn_o, cluster_fetch_enable_o, seq_state_o, seq_err_o
  );

endinterface

// File: rtl/pwr_ack_sync.sv
// ---------------------------------------------------------------------------
// pwr_ack_sync
// Two-flop synchroniser for a level acknowledge coming from another domain.
//   HCLK      : destination clock
//   HRESETn   : synchronous active-low reset (clears both flops)
//   ack_async : asynchronous level input
//   ack_s     : synchronised level, two HCLK edges behind ack_async
// ---------------------------------------------------------------------------
module pwr_ack_sync (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic ack_async,
  output logic ack_s
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= ack_async;
      sync_reg <= meta_reg;
    end
  end

  assign ack_s = sync_reg;

endmodule

// File: rtl/cluster_pwr_seq.sv
// ---------------------------------------------------------------------------
// cluster_pwr_seq
// Turns software cluster controls into an ordered power-up / power-down
// sequence: power switch -> clock gate -> isolation -> reset -> fetch enable,
// and the reverse on the way down. Fetch enable and reset release can only
// reach the cluster from RUN, i.e. once it is powered, clocked, de-isolated.
//   HCLK, HRESETn : clock, synchronous active-low reset
//   bus (slave)   : software controls, pwr_ack_i, cluster controls, status
// ---------------------------------------------------------------------------
module cluster_pwr_seq
  import cluster_pwr_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  cluster_pwr_seq_if.slave  bus
);

  // Terminal counts: a wait of N cycles ends when the counter shows N-1.
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ACK_LAST    = CNT_WIDTH'(ACK_TIMEOUT - 1);

  logic                 ack_s;
  logic                 target;
  seq_state_e           state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 pwr_en_reg;
  logic                 clk_en_reg;
  logic                 iso_reg;
  logic                 rstn_reg;
  logic                 fetch_reg;
  logic                 err_reg;

  pwr_ack_sync u_ack_sync (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ack_async (bus.pwr_ack_i),
    .ack_s     (ack_s)
  );

  assign target = bus.cluster_pow_i & ~bus.cluster_byp_i;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg  <= SEQ_OFF;
      cnt_reg    <= '0;
      pwr_en_reg <= 1'b0;
      clk_en_reg <= 1'b0;
      iso_reg    <= 1'b1;
      rstn_reg   <= 1'b0;
      fetch_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      // Every transition below clears the counter explicitly.
      cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      case (state_reg)
        SEQ_OFF: begin
          cnt_reg    <= '0;
          pwr_en_reg <= 1'b0;
          clk_en_reg <= 1'b0;
          iso_reg    <= 1'b1;
          rstn_reg   <= 1'b0;
          fetch_reg  <= 1'b0;
          if (target) begin
            state_reg  <= SEQ_PWR_UP;
            pwr_en_reg <= 1'b1;
          end
        end

        SEQ_PWR_UP: begin
          if (!target) begin
            state_reg <= SEQ_RST_DN;
            cnt_reg   <= '0;
          end else if (ack_s) begin
            state_reg  <= SEQ_CLK_UP;
            clk_en_reg <= 1'b1;
            cnt_reg    <= '0;
          end else if (cnt_reg == ACK_LAST) begin
            // Switch never acknowledged: flag it and back the power out.
            err_reg    <= 1'b1;
            state_reg  <= SEQ_PWR_DN_WAIT;
            pwr_en_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end

        SEQ_CLK_UP: begin
          if (!target) begin
            state_reg <= SEQ_RST_DN;
            cnt_reg   <= '0;
          end else if (cnt_reg == SETTLE_LAST) begin
            state_reg <= SEQ_DEISO;
            iso_reg   <= 1'b0;
            cnt_reg   <= '0;
          end
        end

        SEQ_DEISO: begin
          if (!target) begin
            state_reg <= SEQ_RST_DN;
            cnt_reg   <= '0;
          end else if (cnt_reg == RST_LAST) begin
            state_reg <= SEQ_RUN;
            rstn_reg  <= bus.cluster_rstn_i;
            fetch_reg <= bus.cluster_fetch_enable_i & bus.cluster_rstn_i;
            cnt_reg   <= '0;
          end
        end

        SEQ_RUN: begin
          cnt_reg <= '0;
          if (!target) begin
            state_reg <= SEQ_RST_DN;
            rstn_reg  <= 1'b0;
            fetch_reg <= 1'b0;
          end else begin
            rstn_reg  <= bus.cluster_rstn_i;
            fetch_reg <= bus.cluster_fetch_enable_i & bus.cluster_rstn_i;
          end
        end

        SEQ_RST_DN: begin
          // Requests are ignored here: power-down always runs to OFF.
          rstn_reg  <= 1'b0;
          fetch_reg <= 1'b0;
          if (cnt_reg == RST_LAST) begin
            state_reg  <= SEQ_PWR_DN_WAIT;
            iso_reg    <= 1'b1;
            clk_en_reg <= 1'b0;
            pwr_en_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end

        SEQ_PWR_DN_WAIT: begin
          if (!ack_s) begin
            state_reg <= SEQ_OFF;
            cnt_reg   <= '0;
          end else if (cnt_reg == ACK_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= SEQ_OFF;
            cnt_reg   <= '0;
          end
        end

        default: begin
          state_reg  <= SEQ_OFF;
          cnt_reg    <= '0;
          pwr_en_reg <= 1'b0;
          clk_en_reg <= 1'b0;
          iso_reg    <= 1'b1;
          rstn_reg   <= 1'b0;
          fetch_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cluster_pwr_en_o       = pwr_en_reg;
  assign bus.cluster_clk_en_o       = clk_en_reg;
  assign bus.cluster_iso_o          = iso_reg;
  assign bus.cluster_rstn_o         = rstn_reg;
  assign bus.cluster_fetch_enable_o = fetch_reg;
  assign bus.seq_state_o            = state_reg;
  assign bus.seq_err_o              = err_reg;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_cluster_pwr_seq
// Directed, table-driven bench for cluster_pwr_seq with default timing
// (SETTLE=16, RST=8, ACK_TIMEOUT=1024). Each record holds inputs for a run of
// n cycles and the outputs expected after the last of those edges, packed as
// {state[2:0], pwr_en, clk_en, iso, rstn, fetch, err}.
// ---------------------------------------------------------------------------
module tb_cluster_pwr_seq;
  import cluster_pwr_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  cluster_pwr_seq_if bus_if ();

  cluster_pwr_seq dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_if)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int         n;
    logic [4:0] in;   // {pow, byp, rstn_i, fetch_i, ack}
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input int n, input logic [4:0] in,
                     input seq_state_e st, input logic [5:0] o);
    vec_t v;
    v.n   = n;
    v.in  = in;
    v.exp = {st, o};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] in);
    bus_if.cluster_pow_i          = in[4];
    bus_if.cluster_byp_i          = in[3];
    bus_if.cluster_rstn_i         = in[2];
    bus_if.cluster_fetch_enable_i = in[1];
    bus_if.pwr_ack_i              = in[0];
  endtask

  // Advance n edges, then settle 1 time unit away from the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {bus_if.seq_state_o, bus_if.cluster_pwr_en_o, bus_if.cluster_clk_en_o,
           bus_if.cluster_iso_o, bus_if.cluster_rstn_o,
           bus_if.cluster_fetch_enable_o, bus_if.seq_err_o};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, got, exp);
    end else begin
      $display("ok   %s out=%b", name, got);
    end
  endtask

  initial begin
    // Output nibbles: {pwr, clk, iso, rstn, fetch, err}
    // Power-up with ack arriving a few cycles after pwr_en.
    add(1,    5'b10110, SEQ_PWR_UP,      6'b101000);
    add(4,    5'b10110, SEQ_PWR_UP,      6'b101000);
    add(2,    5'b10111, SEQ_PWR_UP,      6'b101000); // ack still in synchroniser
    add(1,    5'b10111, SEQ_CLK_UP,      6'b111000);
    add(15,   5'b10111, SEQ_CLK_UP,      6'b111000);
    add(1,    5'b10111, SEQ_DEISO,       6'b110000); // 16th settle cycle ends
    add(7,    5'b10111, SEQ_DEISO,       6'b110000);
    add(1,    5'b10111, SEQ_RUN,         6'b110110);
    // Software reset / fetch gating inside RUN.
    add(1,    5'b10011, SEQ_RUN,         6'b110000);
    add(1,    5'b10101, SEQ_RUN,         6'b110100);
    add(1,    5'b10111, SEQ_RUN,         6'b110110);
    // Power-down from RUN.
    add(1,    5'b00111, SEQ_RST_DN,      6'b110000);
    add(7,    5'b00111, SEQ_RST_DN,      6'b110000);
    add(1,    5'b00111, SEQ_PWR_DN_WAIT, 6'b001000);
    add(3,    5'b00111, SEQ_PWR_DN_WAIT, 6'b001000);
    add(2,    5'b00110, SEQ_PWR_DN_WAIT, 6'b001000); // ack drop still in sync
    add(1,    5'b00110, SEQ_OFF,         6'b001000);
    // Bypass holds OFF.
    add(3,    5'b11110, SEQ_OFF,         6'b001000);
    // Abort in CLK_UP, request reasserted during power-down.
    add(1,    5'b10111, SEQ_PWR_UP,      6'b101000);
    add(1,    5'b10111, SEQ_PWR_UP,      6'b101000);
    add(1,    5'b10111, SEQ_CLK_UP,      6'b111000);
    add(1,    5'b00111, SEQ_RST_DN,      6'b111000);
    add(8,    5'b10111, SEQ_PWR_DN_WAIT, 6'b001000);
    add(2,    5'b10110, SEQ_PWR_DN_WAIT, 6'b001000);
    add(1,    5'b10110, SEQ_OFF,         6'b001000);
    add(1,    5'b10110, SEQ_PWR_UP,      6'b101000);
    // Ack never arrives: timeout on the 1024th PWR_UP cycle.
    add(1023, 5'b10110, SEQ_PWR_UP,      6'b101000);
    add(1,    5'b10110, SEQ_PWR_DN_WAIT, 6'b001001);
    add(1,    5'b10110, SEQ_OFF,         6'b001001);
    // Successful sequence afterwards, error stays sticky.
    add(1,    5'b10111, SEQ_PWR_UP,      6'b101001);
    add(2,    5'b10111, SEQ_CLK_UP,      6'b111001);
    add(16,   5'b10111, SEQ_DEISO,       6'b110001);
    add(8,    5'b10111, SEQ_RUN,         6'b110111);

    drive(5'b00000);
    HRESETn = 1'b0;
    tick(2);
    check("reset", {SEQ_OFF, 6'b001000});
    HRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      tick(vecs[i].n);
      check($sformatf("vec%0d n=%0d in=%b", i, vecs[i].n, vecs[i].in), vecs[i].exp);
    end

    // HRESETn pulse while in RUN snaps everything to OFF values.
    HRESETn = 1'b0;
    tick(1);
    check("rst_in_run", {SEQ_OFF, 6'b001000});
    HRESETn = 1'b1;
    tick(1);
    check("after_rst_pwr_up", {SEQ_PWR_UP, 6'b101000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
